// File: rtl/nrisc_mul_seq_pkg.sv
// Shared definitions for the NRISC multiply sequencer:
// ULA control codes and sequencer state encoding.
package nrisc_mul_seq_pkg;

    localparam logic [3:0] ULA_ADD = 4'b0000;
    localparam logic [3:0] ULA_SHL = 4'b1100;

    localparam int ULA_SHAMT_W = 5;
    localparam int TAM_MAX     = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EVAL = 3'd1,
        S_ADD  = 3'd2,
        S_SHL  = 3'd3,
        S_DONE = 3'd4
    } mul_state_t;

    typedef struct packed {
        logic [TAM_MAX-1:0] a;
        logic [TAM_MAX-1:0] b;
        logic [3:0]         ctrl;
    } ula_req_t;

    function automatic logic is_busy_state(input mul_state_t s);
        return s != S_IDLE;
    endfunction

endpackage

// File: rtl/nrisc_mul_seq_ula_mux.sv
// ULA operand/control selector: core passthrough while granted,
// sequencer-driven otherwise.
module nrisc_ula_mux
    import nrisc_mul_seq_pkg::*;
#(
    parameter int TAM = 16
) (
    input  logic           i_core_gnt,
    input  logic [TAM-1:0] i_core_a,
    input  logic [TAM-1:0] i_core_b,
    input  logic [3:0]     i_core_ctrl,
    input  logic [TAM-1:0] i_seq_a,
    input  logic [TAM-1:0] i_seq_b,
    input  logic [3:0]     i_seq_ctrl,
    output logic [TAM-1:0] o_ula_a,
    output logic [TAM-1:0] o_ula_b,
    output logic [3:0]     o_ula_ctrl
);

    always_comb begin
        o_ula_a    = i_seq_a;
        o_ula_b    = i_seq_b;
        o_ula_ctrl = i_seq_ctrl;
        if (i_core_gnt) begin
            o_ula_a    = i_core_a;
            o_ula_b    = i_core_b;
            o_ula_ctrl = i_core_ctrl;
        end
    end

endmodule

// File: rtl/nrisc_mul_seq.sv
// Shift-and-add multiply sequencer driving the shared NRISC ULA;
// product is truncated to TAM bits.
module nrisc_mul_seq
    import nrisc_mul_seq_pkg::*;
#(
    parameter int TAM = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [TAM-1:0] op_a,
    input  logic [TAM-1:0] op_b,
    input  logic [TAM-1:0] core_ula_a,
    input  logic [TAM-1:0] core_ula_b,
    input  logic [3:0]     core_ula_ctrl,
    input  logic [TAM-1:0] ula_out,
    input  logic [2:0]     ula_flags,
    output logic [TAM-1:0] ula_a,
    output logic [TAM-1:0] ula_b,
    output logic [3:0]     ula_ctrl,
    output logic           core_gnt,
    output logic           busy,
    output logic           done,
    output logic [TAM-1:0] result,
    output logic           result_zero
);

    generate
        if (TAM > TAM_MAX || TAM < 2) begin : g_bad_tam
            $error("nrisc_mul_seq: TAM out of range");
        end
    endgenerate

    mul_state_t     r_state;
    mul_state_t     w_state_nxt;
    logic [TAM-1:0] r_acc;
    logic [TAM-1:0] r_mcand;
    logic [TAM-1:0] r_mplier;
    logic [TAM-1:0] r_result;
    logic [TAM-1:0] w_seq_a;
    logic [TAM-1:0] w_seq_b;
    logic [3:0]     w_seq_ctrl;
    logic           w_core_gnt;
    logic [2:0]     w_unused_flags;

    // Flags are reserved; carry is deliberately ignored (wrap-around).
    assign w_unused_flags = ula_flags;

    always_comb begin
        w_state_nxt = r_state;
        w_seq_a     = r_acc;
        w_seq_b     = '0;
        w_seq_ctrl  = ULA_ADD;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                if (r_mplier == '0) begin
                    w_state_nxt = S_DONE;
                end else if (r_mplier[0]) begin
                    w_state_nxt = S_ADD;
                end else begin
                    w_state_nxt = S_SHL;
                end
            end
            S_ADD: begin
                w_seq_a     = r_acc;
                w_seq_b     = r_mcand;
                w_seq_ctrl  = ULA_ADD;
                w_state_nxt = S_SHL;
            end
            S_SHL: begin
                w_seq_a     = r_mcand;
                w_seq_b     = TAM'(1);
                w_seq_ctrl  = ULA_SHL;
                w_state_nxt = S_EVAL;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= op_a;
                        r_mplier <= op_b;
                        r_acc    <= '0;
                    end
                end
                S_ADD: begin
                    r_acc <= ula_out;
                end
                S_SHL: begin
                    r_mcand  <= ula_out;
                    r_mplier <= r_mplier >> 1;
                end
                S_DONE: begin
                    r_result <= r_acc;
                end
                default: begin
                end
            endcase
        end
    end

    assign w_core_gnt  = !is_busy_state(r_state);
    assign core_gnt    = w_core_gnt;
    assign busy        = !w_core_gnt;
    assign done        = (r_state == S_DONE);
    assign result      = r_result;
    assign result_zero = (r_result == '0);

    nrisc_ula_mux #(
        .TAM(TAM)
    ) u_ula_mux (
        .i_core_gnt (w_core_gnt),
        .i_core_a   (core_ula_a),
        .i_core_b   (core_ula_b),
        .i_core_ctrl(core_ula_ctrl),
        .i_seq_a    (w_seq_a),
        .i_seq_b    (w_seq_b),
        .i_seq_ctrl (w_seq_ctrl),
        .o_ula_a    (ula_a),
        .o_ula_b    (ula_b),
        .o_ula_ctrl (ula_ctrl)
    );

endmodule

// File: tb/tb_nrisc_mul_seq.sv
// Directed bench for nrisc_mul_seq with a behavioural ULA
// answering ADD and SHL.
module tb_nrisc_mul_seq;

    localparam int TAM = 16;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [TAM-1:0] op_a;
    logic [TAM-1:0] op_b;
    logic [TAM-1:0] core_ula_a;
    logic [TAM-1:0] core_ula_b;
    logic [3:0]     core_ula_ctrl;
    logic [TAM-1:0] ula_out;
    logic [2:0]     ula_flags;
    logic [TAM-1:0] ula_a;
    logic [TAM-1:0] ula_b;
    logic [3:0]     ula_ctrl;
    logic           core_gnt;
    logic           busy;
    logic           done;
    logic [TAM-1:0] result;
    logic           result_zero;

    int n_vec;
    int n_err;

    nrisc_mul_seq #(.TAM(TAM)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op_a         (op_a),
        .op_b         (op_b),
        .core_ula_a   (core_ula_a),
        .core_ula_b   (core_ula_b),
        .core_ula_ctrl(core_ula_ctrl),
        .ula_out      (ula_out),
        .ula_flags    (ula_flags),
        .ula_a        (ula_a),
        .ula_b        (ula_b),
        .ula_ctrl     (ula_ctrl),
        .core_gnt     (core_gnt),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .result_zero  (result_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minimal ULA: ADD and SHL only, carry out of TAM bits dropped.
    always_comb begin
        ula_out = '0;
        case (ula_ctrl)
            4'b0000: ula_out = ula_a + ula_b;
            4'b1100: ula_out = ula_a << ula_b[4:0];
            default: ula_out = '0;
        endcase
        ula_flags = {ula_out[TAM-1], ula_out == '0, 1'b0};
    end

    task automatic start_op(input logic [TAM-1:0] a, input logic [TAM-1:0] b);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy === 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec++;
        if ({busy, done, core_gnt, result_zero} !== 4'b0011 || result !== '0) begin
            n_err++;
            $display("FAIL reset: busy/done/gnt/rz=%b result=%h required 0011 0000",
                     {busy, done, core_gnt, result_zero}, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || core_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: busy=%b gnt=%b required 0 1", busy, core_gnt);
        end
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        core_ula_a    = 16'hAAAA;
        core_ula_b    = 16'h5555;
        core_ula_ctrl = 4'b0110;
        #1;
        n_vec++;
        if (ula_a !== 16'hAAAA || ula_b !== 16'h5555 || ula_ctrl !== 4'b0110) begin
            n_err++;
            $display("FAIL passthrough: a=%h b=%h c=%b required aaaa 5555 0110",
                     ula_a, ula_b, ula_ctrl);
        end
        start_op(16'd3, 16'd5);
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            core_ula_a = core_ula_a + 16'h0101;
            #1;
            n_vec++;
            case (n)
                1: if (ula_a !== 16'd0 || ula_b !== 16'd0 || ula_ctrl !== 4'b0000) begin
                    n_err++;
                    $display("FAIL busy_eval_drive: a=%h b=%h c=%b required 0 0 0000",
                             ula_a, ula_b, ula_ctrl);
                end
                2: if (ula_a !== 16'd0 || ula_b !== 16'd3 || ula_ctrl !== 4'b0000) begin
                    n_err++;
                    $display("FAIL busy_add_drive: a=%h b=%h c=%b required 0 3 0000",
                             ula_a, ula_b, ula_ctrl);
                end
                default: if (ula_a !== 16'd3 || ula_b !== 16'd1 || ula_ctrl !== 4'b1100) begin
                    n_err++;
                    $display("FAIL busy_shl_drive: a=%h b=%h c=%b required 3 1 1100",
                             ula_a, ula_b, ula_ctrl);
                end
            endcase
        end
        wait_idle();
    endtask

    task automatic test_basic();
        int done_cyc;
        int n_done;
        int bad_busy;
        logic [TAM-1:0] res;
        logic rz;
        done_cyc = 0;
        n_done   = 0;
        bad_busy = 0;
        res      = '0;
        rz       = 1'b1;
        start_op(16'd3, 16'd5);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (done_cyc == 0) done_cyc = n;
            end
            if (n <= 10 && (busy !== 1'b1 || core_gnt !== 1'b0)) bad_busy++;
            if (n > 10 && (busy !== 1'b0 || core_gnt !== 1'b1)) bad_busy++;
            if (n == 11) begin
                res = result;
                rz  = result_zero;
            end
        end
        n_vec++;
        if (done_cyc != 10 || n_done != 1) begin
            n_err++;
            $display("FAIL basic_done: cycle=%0d pulses=%0d required 10 1", done_cyc, n_done);
        end
        n_vec++;
        if (res !== 16'd15 || rz !== 1'b0) begin
            n_err++;
            $display("FAIL basic_result: %h rz=%b required 000f 0", res, rz);
        end
        n_vec++;
        if (bad_busy != 0) begin
            n_err++;
            $display("FAIL basic_busy_gnt: %0d bad cycles required 0", bad_busy);
        end
    endtask

    task automatic test_zero();
        int done_cyc;
        int bad_drive;
        done_cyc  = 0;
        bad_drive = 0;
        start_op(16'h1234, 16'h0000);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (done === 1'b1 && done_cyc == 0) done_cyc = n;
            if (busy === 1'b1 && (ula_b !== '0 || ula_ctrl !== 4'b0000)) bad_drive++;
        end
        n_vec++;
        if (done_cyc != 2) begin
            n_err++;
            $display("FAIL zero_done: cycle=%0d required 2", done_cyc);
        end
        n_vec++;
        if (result !== 16'd0 || result_zero !== 1'b1) begin
            n_err++;
            $display("FAIL zero_result: %h rz=%b required 0000 1", result, result_zero);
        end
        n_vec++;
        if (bad_drive != 0) begin
            n_err++;
            $display("FAIL zero_no_addshl: %0d cycles required 0", bad_drive);
        end
    endtask

    task automatic test_wrap();
        int done_cyc;
        done_cyc = 0;
        start_op(16'hFFFF, 16'hFFFF);
        for (int n = 1; n <= 52; n++) begin
            @(negedge clk);
            if (done === 1'b1 && done_cyc == 0) done_cyc = n;
        end
        n_vec++;
        if (done_cyc != 50) begin
            n_err++;
            $display("FAIL wrap_done: cycle=%0d required 50", done_cyc);
        end
        n_vec++;
        if (result !== 16'h0001 || result_zero !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_result: %h rz=%b required 0001 0", result, result_zero);
        end
    endtask

    task automatic test_start_ignored();
        int n_done;
        int done_cyc;
        int bad_idle;
        n_done   = 0;
        done_cyc = 0;
        bad_idle = 0;
        start_op(16'd3, 16'd5);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                if (done_cyc == 0) done_cyc = n;
            end
            if (n >= 11 && busy !== 1'b0) bad_idle++;
            if (n == 3 || n == 10) begin
                op_a  = 16'd7;
                op_b  = 16'd7;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        n_vec++;
        if (n_done != 1 || done_cyc != 10) begin
            n_err++;
            $display("FAIL ignore_done: pulses=%0d cycle=%0d required 1 10", n_done, done_cyc);
        end
        n_vec++;
        if (result !== 16'd15) begin
            n_err++;
            $display("FAIL ignore_result: %h required 000f", result);
        end
        n_vec++;
        if (bad_idle != 0) begin
            n_err++;
            $display("FAIL ignore_back_to_idle: %0d busy cycles required 0", bad_idle);
        end
    endtask

    task automatic test_reset_mid();
        int done_cyc;
        start_op(16'd3, 16'd5);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, core_gnt} !== 3'b001 || result !== '0 || result_zero !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid: busy/done/gnt=%b result=%h required 001 0000",
                     {busy, done, core_gnt}, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        done_cyc = 0;
        start_op(16'd6, 16'd7);
        for (int n = 1; n <= 13; n++) begin
            @(negedge clk);
            if (done === 1'b1 && done_cyc == 0) done_cyc = n;
        end
        n_vec++;
        if (done_cyc != 11 || result !== 16'd42) begin
            n_err++;
            $display("FAIL reset_then_6x7: cycle=%0d result=%0d required 11 42",
                     done_cyc, result);
        end
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        start         = 1'b0;
        op_a          = '0;
        op_b          = '0;
        core_ula_a    = '0;
        core_ula_b    = '0;
        core_ula_ctrl = '0;
        test_reset();
        test_passthrough();
        test_basic();
        test_zero();
        test_wrap();
        test_start_ignored();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nrisc_mul_seq.md
Name: nrisc_mul_seq

Overview:
Multi-cycle unsigned multiply sequencer for NRISC. It performs TAM x TAM -> TAM (truncated) shift-and-add multiplication by driving the shared NRISC_ULA with ADD and SHL operations.
It also owns the ULA input mux. While idle, the core's ULA operands and control pass straight through. While busy, the sequencer drives the ULA and the core is stalled. It sits beside the execute stage, between core decode/operand logic and the ULA instance.

Parameters:
TAM, 16, datapath width in bits; must equal the ULA TAM; TAM <= 32 (ULA shift amount field is 5 bits).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request multiply; sampled only in IDLE
op_a  in  TAM  multiplicand, sampled with start
op_b  in  TAM  multiplier, sampled with start
core_ula_a  in  TAM  core operand A for passthrough
core_ula_b  in  TAM  core operand B for passthrough
core_ula_ctrl  in  4  core ULA control for passthrough
ula_out  in  TAM  ULA_OUT from the ULA
ula_flags  in  3  ULA flags {minus,zero,carry}; unused internally, reserved
ula_a  out  TAM  to ULA_A
ula_b  out  TAM  to ULA_B
ula_ctrl  out  4  to ULA_ctrl
core_gnt  out  1  1 = core owns the ULA (state IDLE)
busy  out  1  1 = state != IDLE
done  out  1  one-cycle pulse, result valid
result  out  TAM  product, low TAM bits
result_zero  out  1  result == 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, acc=0, mcand=0, mplier=0, result=0. Consequently done=0, busy=0, core_gnt=1, result_zero=1.
- Reset mid-operation: immediate return to IDLE with all registers cleared. The partial product is discarded and no done pulse is produced.
- ULA control encoding: ctrl[3:1] selects the operation, ctrl[0] is the modifier.
  - ADD = 4'b0000.
  - SHL = 4'b1100, with ula_b = 1.
- Mux (combinational):
  - In IDLE: ula_a/ula_b/ula_ctrl = core_ula_a/core_ula_b/core_ula_ctrl.
  - In all other states: driven by the sequencer as listed below.
- IDLE:
  - If start=1: mcand<=op_a, mplier<=op_b, acc<=0, go to EVAL.
  - Otherwise hold.
- EVAL:
  - Drives the IDLE-safe default ula_a=acc, ula_b=0, ctrl=ADD.
  - If mplier==0 -> DONE (early termination).
  - Else if mplier[0]==1 -> ADD.
  - Else -> SHL.
- ADD: ula_a=acc, ula_b=mcand, ctrl=ADD; acc<=ula_out; go to SHL.
- SHL: ula_a=mcand, ula_b=1, ctrl=SHL; mcand<=ula_out, mplier<=mplier>>1 (local, zero fill); go to EVAL.
- DONE: result<=acc, done=1 for this cycle only; go to IDLE.
- Output registers: result holds its value until the next DONE. result_zero is decoded from the result register.
- Timing:
  - start is sampled at edge k; EVAL is the state after k.
  - Each set multiplier bit costs 3 cycles (EVAL, ADD, SHL); each clear bit below the MSB one costs 2.
  - Final EVAL plus DONE cost 2 cycles.
  - done is high in cycle N after edge k, where N = 3*ones + 2*(clear bits below MSB one) + 2.
  - Minimum N=2 (op_b=0); maximum N=3*TAM+2.
- Overflow: bits above TAM-1 are silently dropped; the ULA carry is ignored. This gives a wrap-around product equal to (op_a*op_b) mod 2^TAM.
- start while busy (including the DONE cycle) is ignored with no queuing; the core must wait for core_gnt.
- start and core ULA use in the same IDLE cycle: the core op completes that cycle through passthrough; the sequencer takes over next cycle.

Decomposition:
- const.v: ULA control codes (ULA_ADD=4'b0000, ULA_SHL=4'b1100) and state encodings (IDLE, EVAL, ADD, SHL, DONE, 3-bit), so the decoder and ULA share one definition.
- One natural sub-module: nrisc_ula_mux, the combinational 2:1 selection of {a,b,ctrl} on core_gnt.
- The FSM and datapath registers stay in nrisc_mul_seq.

Test Plan:
1. op_a=3, op_b=5, start one cycle -> done pulse in cycle 10 after start, result=15, result_zero=0, busy=1 for cycles 1..10, core_gnt=0 for the same cycles.
2. op_a=0x1234, op_b=0 -> done in cycle 2, result=0, result_zero=1; no ADD/SHL ctrl ever driven.
3. TAM=16, op_a=0xFFFF, op_b=0xFFFF -> done in cycle 50, result=0x0001 (wrap-around).
4. During a busy op, pulse start with op_a=7, op_b=7 -> ignored; the first product is unaffected, one done pulse only, and the FSM returns to IDLE.
5. Deassert rst_n mid-op (cycle 4 of case 1) -> state=IDLE, busy=0, done=0, result=0, and core_gnt=1 asynchronously; next start of 6*7 gives 42.
6. In IDLE, core_ula_a=0xAAAA, core_ula_b=0x5555, core_ula_ctrl=4'b0110 -> ula_a/ula_b/ula_ctrl equal the core inputs in the same cycle; while busy, they do not track core inputs.
